// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent positive-edge JK flip-flops with a shared clock,
// synchronous active-high reset and a combinational complementary output.
module jk_flip_flop #(
    parameter int unsigned            WIDTH       = 1,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    // Characteristic equation per bit: J sets a cleared bit, ~K keeps a set bit.
    // This covers hold (00), reset (01), set (10) and toggle (11) bitwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= (J & ~Q) | (~K & Q);
        end
    end

    assign Qn = ~Q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Scoreboard bench for jk_flip_flop: a 1-bit and a 4-bit (RESET_VALUE=1010) bank
// driven together; expectations are queued by the driver and popped by a monitor.
module tb_jk_flip_flop;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [0:0] j1, k1, q1, qn1;
    logic [3:0] j4, k4, q4, qn4;

    jk_flip_flop #(.WIDTH(1)) u_narrow (
        .clk (clk), .rst (rst), .J (j1), .K (k1), .Q (q1), .Qn (qn1)
    );

    jk_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_wide (
        .clk (clk), .rst (rst), .J (j4), .K (k4), .Q (q4), .Qn (qn4)
    );

    typedef struct packed {
        logic [0:0] q1;
        logic [3:0] q4;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference state: value each bank should hold after the next edge.
    logic [0:0] m1;
    logic [3:0] m4;

    function automatic logic jk_rule(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expectation.
    // A literal expectation (use1/use4) replaces the model value for directed steps.
    task automatic step(input logic r,
                        input logic [0:0] nj1, input logic [0:0] nk1,
                        input logic [3:0] nj4, input logic [3:0] nk4,
                        input logic use1, input logic [0:0] lit1,
                        input logic use4, input logic [3:0] lit4,
                        input logic pulse);
        exp_t e;
        @(negedge clk);
        rst = r;
        j1 = nj1; k1 = nk1;
        j4 = nj4; k4 = nk4;
        if (r) begin
            m1 = 1'b0;
            m4 = 4'b1010;
        end else begin
            m1[0] = jk_rule(m1[0], nj1[0], nk1[0]);
            for (int i = 0; i < 4; i++) m4[i] = jk_rule(m4[i], nj4[i], nk4[i]);
        end
        e.q1 = use1 ? lit1 : m1;
        e.q4 = use4 ? lit4 : m4;
        sb.push_back(e);
        if (pulse) begin
            #1 j1 = 1'b1; j4 = 4'b1111;
            #2 j1 = nj1;  j4 = nj4;
        end
    endtask

    // Narrow-bank directed step; the wide bank gets random J/K checked by the model.
    task automatic n_step(input logic r, input logic j, input logic k, input logic lit);
        step(r, j, k, 4'($urandom), 4'($urandom), 1'b1, lit, 1'b0, 4'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("narrow_q",  {3'b0, q1},  {3'b0, e.q1});
                check("narrow_qn", {3'b0, qn1}, {3'b0, ~e.q1});
                check("wide_q",    q4,  e.q4);
                check("wide_qn",   qn4, ~e.q4);
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        j1 = '0; k1 = '0; j4 = '0; k4 = '0;
        m1 = 1'b0; m4 = 4'b1010;

        // Reset wins over J=K=1 and holds over several edges.
        repeat (4) n_step(1'b1, 1'b1, 1'b1, 1'b0);

        // Truth table from Q=0.
        n_step(1'b0, 1'b0, 1'b0, 1'b0);
        n_step(1'b0, 1'b1, 1'b0, 1'b1);
        n_step(1'b0, 1'b0, 1'b1, 1'b0);
        n_step(1'b0, 1'b1, 1'b1, 1'b1);

        // Hold after set, with J pulsed between edges.
        n_step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000,
                        1'b1, 1'b1, 1'b0, 4'b0, 1'b1);

        // Toggle run from Q=0.
        n_step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) n_step(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);

        // Toggle run from Q=1 with reset on the third edge.
        n_step(1'b0, 1'b1, 1'b0, 1'b1);
        n_step(1'b0, 1'b1, 1'b1, 1'b0);
        n_step(1'b0, 1'b1, 1'b1, 1'b1);
        n_step(1'b1, 1'b1, 1'b1, 1'b0);
        n_step(1'b0, 1'b1, 1'b1, 1'b1);
        n_step(1'b0, 1'b1, 1'b1, 1'b0);

        // Wide bank: reset to 1010, then mixed set/toggle/reset/hold.
        step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b1010, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'b1100, 4'b0110, 1'b1, 1'b0, 1'b1, 4'b1100, 1'b0);

        // Random traffic with occasional reset, checked against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15) == 0) ? 1'b1 : 1'b0,
                 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                 1'b0, 1'b0, 1'b0, 4'b0, ($urandom_range(7) == 0) ? 1'b1 : 1'b0);
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
